// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: occupancy states,
// per-boundary payload widths and a small occupancy helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_BUSY  = 2'd1,
        PIPE_FULL  = 2'd2
    } pipe_state_e;

    // Field widths that make up each stage boundary bus.
    localparam int XLEN       = 32;
    localparam int INSTR_W    = 32;
    localparam int REG_IDX_W  = 5;
    localparam int ALU_OP_W   = 5;
    localparam int MEM_CTRL_W = 4;

    localparam int IF_ID_W  = XLEN + INSTR_W;
    localparam int ID_EX_W  = XLEN + 2 * XLEN + REG_IDX_W + ALU_OP_W + MEM_CTRL_W;
    localparam int EX_MEM_W = XLEN + XLEN + REG_IDX_W + MEM_CTRL_W;
    localparam int MEM_WB_W = XLEN + REG_IDX_W + 1;

    function automatic logic [1:0] entry_count(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Occupancy control for one pipeline stage: tracks MAIN/SKID validity, drives
// upstream ready and tells the datapath which register to load.
module pipe_skid_ctrl
    import pipe_pkg::*;
#(
    parameter bit SKID_EN = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       flush_i,
    input  logic       pin_valid_i,
    input  logic       pout_ready_i,
    output logic       pin_ready_o,
    output logic       main_v_o,
    output logic [1:0] count_o,
    output logic       ld_main_in,
    output logic       ld_main_skid,
    output logic       ld_skid
);

    pipe_state_e state_q, state_d;
    logic        main_v;
    logic        skid_v;
    logic        in_fire;
    logic        out_fire;

    assign main_v   = (state_q != PIPE_EMPTY);
    assign in_fire  = pin_valid_i & pin_ready_o;
    assign out_fire = main_v & pout_ready_i;

    // With a skid entry, ready comes straight off a flop so pout_ready_i never
    // reaches pin_ready_o; without one, ready is the legacy combinational form.
    generate
        if (SKID_EN) begin : g_skid
            logic ready_q;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) ready_q <= 1'b1;
                else          ready_q <= (state_d != PIPE_FULL);
            end

            assign skid_v      = (state_q == PIPE_FULL);
            assign pin_ready_o = ready_q;
        end else begin : g_noskid
            assign skid_v      = 1'b0;
            assign pin_ready_o = !main_v | pout_ready_i;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= PIPE_EMPTY;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_q)
            PIPE_EMPTY: begin
                if (in_fire) begin
                    state_d    = PIPE_BUSY;
                    ld_main_in = 1'b1;
                end
            end
            PIPE_BUSY: begin
                if (in_fire && out_fire) begin
                    ld_main_in = 1'b1;
                end else if (in_fire) begin
                    state_d = PIPE_FULL;
                    ld_skid = 1'b1;
                end else if (out_fire) begin
                    state_d = PIPE_EMPTY;
                end
            end
            PIPE_FULL: begin
                if (out_fire) begin
                    state_d      = PIPE_BUSY;
                    ld_main_skid = 1'b1;
                end
            end
            default: state_d = PIPE_EMPTY;
        endcase
        // Flush wins; a same-cycle out_fire has still been seen downstream.
        if (flush_i) begin
            state_d      = PIPE_EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    assign main_v_o = main_v;
    assign count_o  = entry_count(main_v, skid_v);

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and optional skid entry;
// holds only the payload registers, control lives in pipe_skid_ctrl.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter bit SKID_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             pin_valid_i,
    output logic             pin_ready_o,
    input  logic [WIDTH-1:0] pin_data_i,
    output logic             pout_valid_o,
    input  logic             pout_ready_i,
    output logic [WIDTH-1:0] pout_data_o,
    output logic [1:0]       count_o
);

    logic             main_v;
    logic             ld_main_in;
    logic             ld_main_skid;
    logic             ld_skid;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    pipe_skid_ctrl #(
        .SKID_EN (SKID_EN)
    ) u_ctrl (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .flush_i      (flush_i),
        .pin_valid_i  (pin_valid_i),
        .pout_ready_i (pout_ready_i),
        .pin_ready_o  (pin_ready_o),
        .main_v_o     (main_v),
        .count_o      (count_o),
        .ld_main_in   (ld_main_in),
        .ld_main_skid (ld_main_skid),
        .ld_skid      (ld_skid)
    );

    // MAIN refills either from the input or, when draining FULL, from SKID.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)          main_q <= '0;
        else if (ld_main_in)   main_q <= pin_data_i;
        else if (ld_main_skid) main_q <= skid_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)     skid_q <= '0;
        else if (ld_skid) skid_q <= pin_data_i;
    end

    assign pout_valid_o = main_v;
    assign pout_data_o  = main_q;

endmodule
